// File: rtl/regfile_wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl_if
// Bundles every non-clock/reset signal of the write-back controller.
//   ALU source   : alu_we, alu_waddr[4:0], alu_wdata[31:0]
//   LSU source   : lsu_valid, lsu_waddr[4:0], lsu_wdata[31:0] -> lsu_ready
//   Decode reads : re1/raddr1, re2/raddr2 -> hazard1, hazard2
//   Regfile port : we, waddr[4:0], wdata[31:0]; status busy
// master = the surrounding pipeline that drives sources and reads results,
// slave  = the write-back controller itself.
// -----------------------------------------------------------------------------
interface regfile_wb_ctrl_if;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lsu_valid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;

  modport master (
    output alu_we, alu_waddr, alu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output re1, raddr1, re2, raddr2,
    input  lsu_ready, hazard1, hazard2, we, waddr, wdata, busy
  );

  modport slave (
    input  alu_we, alu_waddr, alu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  re1, raddr1, re2, raddr2,
    output lsu_ready, hazard1, hazard2, we, waddr, wdata, busy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
// Writer side of the register file's single write port. The ALU path is
// single-cycle and always wins the port; LSU results are queued in a small
// FIFO and drained into cycles the ALU leaves free. Queued entries that are
// superseded by a newer ALU write to the same register are marked dead, so
// they pop without writing. Decode is told when a read address matches a
// still-live queued LSU write.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous reset, active-high
//   bus  - regfile_wb_ctrl_if.slave (ALU/LSU sources, decode reads,
//          registered regfile write port, busy)
// -----------------------------------------------------------------------------
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_ctrl_if.slave   bus
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = (PTR_W)'(0);

  // FIFO storage and bookkeeping
  logic [DEPTH-1:0] live_r;
  logic [4:0]       addr_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  // Registered write port
  logic        we_r;
  logic [4:0]  waddr_r;
  logic [31:0] wdata_r;

  // Per-cycle decisions
  logic           full_s;
  logic           alu_issue_s;
  logic           push_s;
  logic           push_live_s;
  logic           head_live_s;
  logic           pop_s;
  logic           pop_wr_s;
  logic           wr_en_s;
  logic [4:0]     wr_addr_s;
  logic [31:0]    wr_data_s;
  logic [PTR_W:0] count_nxt_s;
  logic           hit1_s;
  logic           hit2_s;

  // Handshake, pop and kill decisions for this cycle
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    alu_issue_s = bus.alu_we && (bus.alu_waddr != 5'd0);
    push_s      = bus.lsu_valid && !full_s && !rst;
    // A same-cycle ALU write to the same register is newer, so the pushed
    // entry is born dead; writes to x0 are always dead.
    push_live_s = (bus.lsu_waddr != 5'd0) &&
                  !(bus.alu_we && (bus.alu_waddr == bus.lsu_waddr));
    // Popped slots have their live bit cleared, so an empty FIFO reads 0 here.
    head_live_s = live_r[head_r];
    // Dead heads never need the port; live heads wait for a free port.
    pop_s       = (count_r != CNT_ZERO) && (!head_live_s || !alu_issue_s);
    pop_wr_s    = pop_s && head_live_s;
  end

  // Write-port source select: ALU first, then live FIFO head, else hold
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = waddr_r;
    wr_data_s = wdata_r;
    if (alu_issue_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = bus.alu_waddr;
      wr_data_s = bus.alu_wdata;
    end else if (pop_wr_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = addr_r[head_r];
      wr_data_s = data_r[head_r];
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Read-hazard match against live queued entries
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s = hit1_s | (live_r[i] && (addr_r[i] == bus.raddr1));
      hit2_s = hit2_s | (live_r[i] && (addr_r[i] == bus.raddr2));
    end
  end

  // Control state: pointers, count, live bits and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      live_r  <= {DEPTH{1'b0}};
      we_r    <= 1'b0;
      waddr_r <= 5'd0;
      wdata_r <= 32'd0;
    end else begin
      we_r    <= wr_en_s;
      waddr_r <= wr_addr_s;
      wdata_r <= wr_data_s;
      count_r <= count_nxt_s;
      // WAW kill: the ALU write supersedes every queued write to its target.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_issue_s && (addr_r[i] == bus.alu_waddr)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + PTR_ONE;
      end
      // Tail never aliases head while both push and pop are active.
      if (push_s) begin
        live_r[tail_r] <= push_live_s;
        tail_r         <= tail_r + PTR_ONE;
      end
    end
  end

  // Entry payload storage; needs no reset because live bits gate its use
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_r[tail_r] <= bus.lsu_waddr;
      data_r[tail_r] <= bus.lsu_wdata;
    end
  end

  assign bus.lsu_ready = !full_s && !rst;
  assign bus.hazard1   = !rst && bus.re1 && (bus.raddr1 != 5'd0) && hit1_s;
  assign bus.hazard2   = !rst && bus.re2 && (bus.raddr2 != 5'd0) && hit2_s;
  assign bus.we        = we_r;
  assign bus.waddr     = waddr_r;
  assign bus.wdata     = wdata_r;
  assign bus.busy      = (count_r != CNT_ZERO);

endmodule
